// File: rtl/sha1_core_iter.sv
// rtl/sha1_core_iter.sv - iterative SHA-1 compression engine, ROUNDS_PER_CYCLE rounds per clock
module sha1_core_iter #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] out_digest,
  output logic         busy
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam int EXT_W = 16 + R;
  localparam int EI = $clog2(EXT_W);
  localparam logic [6:0] R7 = 7'(R);
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 5 || R == 8 || R == 10 || R == 16)) begin : g_bad_rounds
      $error("sha1_core_iter: ROUNDS_PER_CYCLE must be one of 1,2,4,5,8,10,16");
    end
    if (N != 32) begin : g_bad_width
      $error("sha1_core_iter: N must be 32");
    end
  endgenerate

  typedef logic [N-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  word_t       win [16];
  word_t       win_nxt [16];
  word_t       a, b, c, d, e;
  word_t       a_nxt, b_nxt, c_nxt, d_nxt, e_nxt;
  logic [159:0] base, h;
  logic        last_step;

  function automatic word_t rotl1(input word_t x);
    return {x[30:0], x[31]};
  endfunction

  function automatic word_t rotl5(input word_t x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic word_t rotl30(input word_t x);
    return {x[1:0], x[31:2]};
  endfunction

  function automatic word_t round_f(input logic [6:0] t, input word_t x, input word_t y, input word_t z);
    if (t < 7'd20)      return (x & y) | (~x & z);
    else if (t < 7'd40) return x ^ y ^ z;
    else if (t < 7'd60) return (x & y) | (x & z) | (y & z);
    else                return x ^ y ^ z;
  endfunction

  function automatic word_t round_k(input logic [6:0] t);
    if (t < 7'd20)      return 32'h5A827999;
    else if (t < 7'd40) return 32'h6ED9EBA1;
    else if (t < 7'd60) return 32'h8F1BBCDC;
    else                return 32'hCA62C1D6;
  endfunction

  // ext holds W_cnt .. W_cnt+15+R: the current window plus the R words that slide in.
  always_comb begin : round_comb
    word_t ext [EXT_W];
    word_t ta, tb, tc, td, te, tmp;
    logic [6:0] t;
    for (int j = 0; j < 16; j++) ext[EI'(j)] = win[4'(j)];
    for (int j = 16; j < EXT_W; j++)
      ext[EI'(j)] = rotl1(ext[EI'(j - 3)] ^ ext[EI'(j - 8)] ^ ext[EI'(j - 14)] ^ ext[EI'(j - 16)]);
    ta = a; tb = b; tc = c; td = d; te = e;
    t = cnt;
    for (int i = 0; i < R; i++) begin
      t   = cnt + 7'(i);
      tmp = rotl5(ta) + round_f(t, tb, tc, td) + round_k(t) + te + ext[EI'(i)];
      te  = td;
      td  = tc;
      tc  = rotl30(tb);
      tb  = ta;
      ta  = tmp;
    end
    for (int j = 0; j < 16; j++) win_nxt[4'(j)] = ext[EI'(j + R)];
    a_nxt = ta; b_nxt = tb; c_nxt = tc; d_nxt = td; e_nxt = te;
  end

  assign last_step = (cnt + R7) == 7'd80;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_ROUND;
      S_ROUND: if (last_step) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      h    <= IV;
      base <= IV;
      a <= '0; b <= '0; c <= '0; d <= '0; e <= '0;
      for (int j = 0; j < 16; j++) win[4'(j)] <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          for (int j = 0; j < 16; j++) win[4'(j)] <= in_block[511 - 32*j -: 32];
          base <= in_first ? IV : h;
          {a, b, c, d, e} <= in_first ? IV : h;
          cnt <= '0;
        end
        S_ROUND: begin
          for (int j = 0; j < 16; j++) win[4'(j)] <= win_nxt[4'(j)];
          {a, b, c, d, e} <= {a_nxt, b_nxt, c_nxt, d_nxt, e_nxt};
          cnt <= cnt + R7;
          if (last_step)
            h <= {base[159:128] + a_nxt, base[127:96] + b_nxt, base[95:64] + c_nxt,
                  base[63:32] + d_nxt, base[31:0] + e_nxt};
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign out_digest = h;

endmodule
